reg_bank_writer: RTL and testbench

- Write side of the 16 x 32-bit register bank; owns the register storage and drives r0..r15 straight into the bank's 16:1 read mux.
- Accepts single-register writes and multi-register burst writes (load-multiple style) over a valid/ready handshake.
- Supports per-byte write enables.
- Signals burst completion to the control unit.

---
 rtl/reg_bank_writer.sv | 171 +++++++++++++++++
 tb/tb_reg_bank_writer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_writer.sv
// reg_bank_writer: write side of the 16 x WIDTH register bank.
// Owns the register storage and presents r0..r15 straight to the read mux.
// Accepts single writes and load-multiple style bursts with per-byte enables,
// and pulses burst_done for one cycle when a burst finishes.
//
// Handshake: a beat transfers on a rising clk edge where wr_valid and
// wr_ready are both high. The source must keep the beat stable while
// wr_valid is high and wr_ready is low. wr_ready drops only during the single
// DONE cycle that follows a burst.
//
// WIDTH must be a multiple of 8. Each byte lane i maps to wr_be[i].
module reg_bank_writer #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [3:0]         wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [WIDTH/8-1:0] wr_be,
    input  logic               burst_start,
    input  logic [3:0]         burst_len,
    output logic               busy,
    output logic               burst_done,
    output logic [1:0]         dbg_state,
    output logic [WIDTH-1:0]   r0,
    output logic [WIDTH-1:0]   r1,
    output logic [WIDTH-1:0]   r2,
    output logic [WIDTH-1:0]   r3,
    output logic [WIDTH-1:0]   r4,
    output logic [WIDTH-1:0]   r5,
    output logic [WIDTH-1:0]   r6,
    output logic [WIDTH-1:0]   r7,
    output logic [WIDTH-1:0]   r8,
    output logic [WIDTH-1:0]   r9,
    output logic [WIDTH-1:0]   r10,
    output logic [WIDTH-1:0]   r11,
    output logic [WIDTH-1:0]   r12,
    output logic [WIDTH-1:0]   r13,
    output logic [WIDTH-1:0]   r14,
    output logic [WIDTH-1:0]   r15
);

    localparam int NB = WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         next_addr_q, next_addr_d;
    logic [3:0]         remaining_q, remaining_d;
    logic               wr_ready_q, wr_ready_d;
    logic               busy_q, busy_d;
    logic               burst_done_q, burst_done_d;
    logic [WIDTH-1:0]   regs_q [16];
    logic [WIDTH-1:0]   regs_d [16];

    logic               wr_fire;
    logic [3:0]         tgt_addr;
    logic [WIDTH-1:0]   merged;

    // A beat transfers only while the registered ready is high.
    assign wr_fire = wr_valid & wr_ready_q;

    // Inside a burst the address comes from the internal pointer; wr_addr is ignored.
    assign tgt_addr = (state_q == BURST) ? next_addr_q : wr_addr;

    // Next-state, burst bookkeeping and byte-merged register update.
    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        remaining_d = remaining_q;
        regs_d      = regs_q;
        merged      = regs_q[tgt_addr];

        for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
                merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end

        if (wr_fire) begin
            regs_d[tgt_addr] = merged;
        end

        case (state_q)
            IDLE: begin
                if (wr_fire && burst_start) begin
                    if (burst_len == 4'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d     = BURST;
                        next_addr_d = 4'(wr_addr + 4'd1);
                        remaining_d = burst_len;
                    end
                end
            end
            BURST: begin
                if (wr_fire) begin
                    next_addr_d = 4'(next_addr_q + 4'd1);
                    remaining_d = 4'(remaining_q - 4'd1);
                    if (remaining_q == 4'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered versions of what the next state implies.
        wr_ready_d   = (state_d != DONE);
        busy_d       = (state_d == BURST);
        burst_done_d = (state_d == DONE);
    end

    // State, handshake outputs and register storage; reset abandons any burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            next_addr_q  <= 4'd0;
            remaining_q  <= 4'd0;
            wr_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            burst_done_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            state_q      <= state_d;
            next_addr_q  <= next_addr_d;
            remaining_q  <= remaining_d;
            wr_ready_q   <= wr_ready_d;
            busy_q       <= busy_d;
            burst_done_q <= burst_done_d;
            regs_q       <= regs_d;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign busy       = busy_q;
    assign burst_done = burst_done_q;
    assign dbg_state  = state_q;

    assign r0  = regs_q[0];
    assign r1  = regs_q[1];
    assign r2  = regs_q[2];
    assign r3  = regs_q[3];
    assign r4  = regs_q[4];
    assign r5  = regs_q[5];
    assign r6  = regs_q[6];
    assign r7  = regs_q[7];
    assign r8  = regs_q[8];
    assign r9  = regs_q[9];
    assign r10 = regs_q[10];
    assign r11 = regs_q[11];
    assign r12 = regs_q[12];
    assign r13 = regs_q[13];
    assign r14 = regs_q[14];
    assign r15 = regs_q[15];

endmodule

// File: tb/tb_reg_bank_writer.sv
// Directed testbench for reg_bank_writer: single writes, byte enables,
// bursts with stalls and wrap, DONE-cycle back-pressure and async reset.
module tb_reg_bank_writer;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic          wr_valid;
    logic          wr_ready;
    logic [3:0]    wr_addr;
    logic [W-1:0]  wr_data;
    logic [3:0]    wr_be;
    logic          burst_start;
    logic [3:0]    burst_len;
    logic          busy;
    logic          burst_done;
    logic [1:0]    dbg_state;
    logic [W-1:0]  r0, r1, r2, r3, r4, r5, r6, r7;
    logic [W-1:0]  r8, r9, r10, r11, r12, r13, r14, r15;
    logic [W-1:0]  r_arr [16];

    reg_bank_writer #(.WIDTH(W), .RESET_VAL('0)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .burst_start(burst_start), .burst_len(burst_len),
        .busy(busy), .burst_done(burst_done), .dbg_state(dbg_state),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13),
        .r14(r14), .r15(r15)
    );

    assign r_arr[0]  = r0;
    assign r_arr[1]  = r1;
    assign r_arr[2]  = r2;
    assign r_arr[3]  = r3;
    assign r_arr[4]  = r4;
    assign r_arr[5]  = r5;
    assign r_arr[6]  = r6;
    assign r_arr[7]  = r7;
    assign r_arr[8]  = r8;
    assign r_arr[9]  = r9;
    assign r_arr[10] = r10;
    assign r_arr[11] = r11;
    assign r_arr[12] = r12;
    assign r_arr[13] = r13;
    assign r_arr[14] = r14;
    assign r_arr[15] = r15;

    // ---------------- scoreboard ----------------
    int           n_checks;
    int           n_errors;
    logic [W-1:0] exp_regs [16];
    logic [W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Compare every register against the model, via an expected queue.
    task automatic check_regs(input string tag);
        for (int i = 0; i < 16; i++) exp_q.push_back(exp_regs[i]);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_r%0d", tag, i), r_arr[i], exp_q.pop_front());
        end
    endtask

    task automatic check_ctl(input string tag, input logic rdy, input logic bsy, input logic dn);
        check({tag, "_ready"}, {31'd0, wr_ready}, {31'd0, rdy});
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, bsy});
        check({tag, "_done"}, {31'd0, burst_done}, {31'd0, dn});
    endtask

    // ---------------- driver tasks ----------------
    // All drives start #1 after a rising edge and end #1 after the next one.
    task automatic beat(input logic [3:0] a, input logic [W-1:0] d, input logic [3:0] be,
                        input logic bs, input logic [3:0] len);
        wr_valid    = 1'b1;
        wr_addr     = a;
        wr_data     = d;
        wr_be       = be;
        burst_start = bs;
        burst_len   = len;
        @(posedge clk);
        #1;
        wr_valid    = 1'b0;
        burst_start = 1'b0;
    endtask

    task automatic idle_cycle();
        wr_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        wr_be       = '0;
        burst_start = 1'b0;
        burst_len   = '0;
        clear_model();

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1) reset state
        check_regs("reset");
        check_ctl("reset", 1'b1, 1'b0, 1'b0);
        check("reset_state", {30'd0, dbg_state}, 32'd0);

        // 2) single writes with byte enables
        beat(4'd5, 32'hDEADBEEF, 4'hF, 1'b0, 4'd0);
        exp_regs[5] = 32'hDEADBEEF;
        check_regs("single1");
        check_ctl("single1", 1'b1, 1'b0, 1'b0);
        beat(4'd5, 32'h11223344, 4'h5, 1'b0, 4'd0);
        exp_regs[5] = 32'hDE22BE44;
        check_regs("single2");
        check_ctl("single2", 1'b1, 1'b0, 1'b0);
        beat(4'd5, 32'hFFFFFFFF, 4'h0, 1'b0, 4'd0);
        check("be_zero_r5", r5, 32'hDE22BE44);
        check_ctl("be_zero", 1'b1, 1'b0, 1'b0);

        // 3) burst at 14, len 3, wrapping, stall after beat 2, beat offered in DONE
        beat(4'd14, 32'hA0, 4'hF, 1'b1, 4'd3);
        check_ctl("b3_beat2", 1'b1, 1'b1, 1'b0);
        beat(4'd9, 32'hA1, 4'hF, 1'b0, 4'd0);      // wr_addr ignored inside burst
        check_ctl("b3_stall", 1'b1, 1'b1, 1'b0);
        idle_cycle();
        check_ctl("b3_beat3", 1'b1, 1'b1, 1'b0);
        beat(4'd2, 32'hA2, 4'hF, 1'b1, 4'd7);      // burst_start ignored inside burst
        check_ctl("b3_beat4", 1'b1, 1'b1, 1'b0);
        // last beat; then hold a fresh beat through the DONE cycle
        wr_valid = 1'b1; wr_addr = 4'd8; wr_data = 32'hA3; wr_be = 4'hF;
        @(posedge clk);
        #1;
        exp_regs[14] = 32'hA0; exp_regs[15] = 32'hA1;
        exp_regs[0]  = 32'hA2; exp_regs[1]  = 32'hA3;
        check_ctl("b3_done", 1'b0, 1'b0, 1'b1);
        wr_addr = 4'd0; wr_data = 32'h000000FF; wr_be = 4'hF;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        check_regs("b3_after");
        check_ctl("b3_idle", 1'b1, 1'b0, 1'b0);

        // 4) single-beat burst
        beat(4'd7, 32'h55, 4'hF, 1'b1, 4'd0);
        exp_regs[7] = 32'h55;
        check_ctl("b0_done", 1'b0, 1'b0, 1'b1);
        check("b0_state", {30'd0, dbg_state}, 32'd2);
        check("b0_r7", r7, 32'h55);
        idle_cycle();
        check_ctl("b0_idle", 1'b1, 1'b0, 1'b0);

        // 5) 16-beat burst from r3 covering the whole bank
        for (int k = 0; k < 16; k++) begin
            beat(k == 0 ? 4'd3 : 4'd0, W'(k + 1), 4'hF, k == 0, 4'd15);
            if (k < 15) begin
                check($sformatf("b15_done_k%0d", k), {31'd0, burst_done}, 32'd0);
                check($sformatf("b15_busy_k%0d", k), {31'd0, busy}, 32'd1);
            end
        end
        check_ctl("b15_done", 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++) exp_regs[(3 + k) % 16] = W'(k + 1);
        check("b15_r3", r3, 32'd1);
        check("b15_r2", r2, 32'd16);
        idle_cycle();
        check_ctl("b15_idle", 1'b1, 1'b0, 1'b0);
        check_regs("b15");

        // 6) async reset in the middle of a 6-beat burst
        beat(4'd10, 32'hC0, 4'hF, 1'b1, 4'd5);
        beat(4'd0, 32'hC1, 4'hF, 1'b0, 4'd0);
        check_ctl("rst_pre", 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        check_regs("rst_mid");
        check_ctl("rst_mid", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_ctl("rst_rel", 1'b1, 1'b0, 1'b0);
        beat(4'd9, 32'h12345678, 4'hF, 1'b0, 4'd0);
        exp_regs[9] = 32'h12345678;
        check_regs("post_rst");
        check_ctl("post_rst", 1'b1, 1'b0, 1'b0);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
